// File: rtl/blake_state_ctrl.sv
// blake_state_ctrl: BLAKE-512 16x64 working state with a 16-round x 8-step G sequencer; start loads v_init, each en step writes a/b/c/d_new back, done pulses after step 127
module blake_state_ctrl (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1023:0] v_init,
  input  logic          en,
  input  logic [63:0]   a_new,
  input  logic [63:0]   b_new,
  input  logic [63:0]   c_new,
  input  logic [63:0]   d_new,
  output logic [1023:0] v_out,
  output logic [6:0]    counter_idx,
  output logic          busy,
  output logic          done
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state;
  logic [1:0] t;
  logic x;
  logic [3:0] ia, ib, ic, id;
  logic [1023:0] v_nxt;
  assign t = counter_idx[1:0];
  assign x = counter_idx[2];
  assign ia = {2'b00, t};
  assign ib = {2'b01, t + {1'b0, x}};
  assign ic = {2'b10, t + {x, 1'b0}};
  assign id = {2'b11, t + {x, x}};
  always_comb begin
    v_nxt = v_out;
    v_nxt[{~ia, 6'd0} +: 64] = a_new;
    v_nxt[{~ib, 6'd0} +: 64] = b_new;
    v_nxt[{~ic, 6'd0} +: 64] = c_new;
    v_nxt[{~id, 6'd0} +: 64] = d_new;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      v_out       <= '0;
      counter_idx <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else if (state == IDLE) begin
      done <= 1'b0;
      if (start) begin
        state       <= RUN;
        v_out       <= v_init;
        counter_idx <= '0;
        busy        <= 1'b1;
      end
    end else begin
      done <= 1'b0;
      if (en) begin
        v_out       <= v_nxt;
        counter_idx <= counter_idx + 7'd1;
        if (&counter_idx) begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_blake_state_ctrl.sv
// tb_blake_state_ctrl: scoreboard bench for blake_state_ctrl with stub and real BLAKE-512 G models
module tb_blake_state_ctrl;
  logic clk = 0, rst = 1, start = 0, en = 1;
  logic [1023:0] v_init = '0, v_out;
  logic [63:0] a_new, b_new, c_new, d_new;
  logic [6:0] counter_idx;
  logic busy, done;
  bit g_stub = 0;
  int errors = 0, checks = 0, cyc = 0, ndone = 0;
  typedef struct {logic [1023:0] v; int due;} exp_t;
  exp_t q[$];
  localparam int mp [8][4] = '{'{0,4,8,12}, '{1,5,9,13}, '{2,6,10,14}, '{3,7,11,15},
                                '{0,5,10,15}, '{1,6,11,12}, '{2,7,8,13}, '{3,4,9,14}};
  localparam int sg [10][16] = '{
    '{0,1,2,3,4,5,6,7,8,9,10,11,12,13,14,15},
    '{14,10,4,8,9,15,13,6,1,12,0,2,11,7,5,3},
    '{11,8,12,0,5,2,15,13,10,14,3,6,7,1,9,4},
    '{7,9,3,1,13,12,11,14,2,6,5,10,4,0,15,8},
    '{9,0,5,7,2,4,10,15,14,1,11,12,6,8,3,13},
    '{2,12,6,10,0,11,8,3,4,13,7,5,15,14,1,9},
    '{12,5,1,15,14,13,4,10,0,7,6,3,9,2,8,11},
    '{13,11,7,14,12,1,3,9,5,0,15,4,8,6,2,10},
    '{6,15,14,9,11,3,0,8,12,2,13,7,1,4,10,5},
    '{10,2,8,4,7,6,1,5,15,11,9,14,3,12,13,0}};
  localparam logic [63:0] cst [16] = '{
    64'h243F6A8885A308D3, 64'h13198A2E03707344, 64'hA4093822299F31D0, 64'h082EFA98EC4E6C89,
    64'h452821E638D01377, 64'hBE5466CF34E90C6C, 64'hC0AC29B7C97C50DD, 64'h3F84D5B5B5470917,
    64'h9216D5D98979FB1B, 64'hD1310BA698DFB5AC, 64'h2FFD72DBD01ADFB7, 64'hB8E1AFED6A267E96,
    64'hBA7C9045F12C7F99, 64'h24A19947B3916CF7, 64'h0801F2E2858EFC16, 64'h636920D871574E69};

  blake_state_ctrl dut (.clk(clk), .rst(rst), .start(start), .v_init(v_init), .en(en),
    .a_new(a_new), .b_new(b_new), .c_new(c_new), .d_new(d_new),
    .v_out(v_out), .counter_idx(counter_idx), .busy(busy), .done(done));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] wd(logic [1023:0] v, int i);
    logic [1023:0] s = v >> ((15 - i) * 64);
    return s[63:0];
  endfunction
  function automatic logic [1023:0] set_w(logic [1023:0] v, int i, logic [63:0] w);
    int sh = (15 - i) * 64;
    return (v & ~({960'b0, {64{1'b1}}} << sh)) | ({960'b0, w} << sh);
  endfunction
  function automatic logic [63:0] ror(logic [63:0] x, int n);
    return (x >> n) | (x << (64 - n));
  endfunction
  function automatic logic [255:0] g_fn(logic [63:0] a, logic [63:0] b, logic [63:0] c,
                                        logic [63:0] d, logic [6:0] st, bit stub);
    int r, i, j, k;
    if (stub) return {a + 64'd1, b + 64'd2, c + 64'd3, d + 64'd4};
    r = int'(st[6:3]) % 10;
    i = int'(st[2:0]);
    j = sg[r][2*i];
    k = sg[r][2*i+1];
    a = a + b + cst[k];
    d = ror(d ^ a, 32);
    c = c + d;
    b = ror(b ^ c, 25);
    a = a + b + cst[j];
    d = ror(d ^ a, 16);
    c = c + d;
    b = ror(b ^ c, 11);
    return {a, b, c, d};
  endfunction
  function automatic logic [1023:0] model(logic [1023:0] v, bit stub);
    logic [255:0] g;
    for (int st = 0; st < 128; st++) begin
      int s = st % 8;
      g = g_fn(wd(v, mp[s][0]), wd(v, mp[s][1]), wd(v, mp[s][2]), wd(v, mp[s][3]), 7'(st), stub);
      v = set_w(v, mp[s][0], g[255:192]);
      v = set_w(v, mp[s][1], g[191:128]);
      v = set_w(v, mp[s][2], g[127:64]);
      v = set_w(v, mp[s][3], g[63:0]);
    end
    return v;
  endfunction
  function automatic logic [1023:0] rnd_v();
    logic [1023:0] v = '0;
    for (int i = 0; i < 16; i++) v = set_w(v, i, {$urandom, $urandom});
    return v;
  endfunction

  always_comb begin
    {a_new, b_new, c_new, d_new} = g_fn(wd(v_out, mp[counter_idx[2:0]][0]), wd(v_out, mp[counter_idx[2:0]][1]),
                                        wd(v_out, mp[counter_idx[2:0]][2]), wd(v_out, mp[counter_idx[2:0]][3]),
                                        counter_idx, g_stub);
  end

  task automatic check(string tag, logic [1023:0] got, logic [1023:0] exp);
    int w = 15;
    checks++;
    if (got !== exp) begin
      errors++;
      for (int i = 15; i >= 0; i--) if (wd(got, i) !== wd(exp, i)) w = i;
      $display("FAIL %s word %0d got %h exp %h", tag, w, wd(got, w), wd(exp, w));
    end
  endtask

  always @(negedge clk) if (done) begin
    exp_t e;
    ndone++;
    if (q.size() == 0) check("spurious_done", done, 0);
    else begin
      e = q.pop_front();
      check("final_v", v_out, e.v);
      check("done_cycle", cyc, e.due);
      check("end_idx", counter_idx, 0);
      check("end_busy", busy, 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_start(logic [1023:0] v, int stall);
    v_init = v;
    start = 1;
    q.push_back('{model(v, g_stub), cyc + 129 + stall});
    tick();
    start = 0;
    check("load_v", v_out, v);
    check("load_busy", busy, 1);
    check("load_idx", counter_idx, 0);
  endtask
  task automatic step_until(int tgt);
    for (int i = 0; i < 200 && counter_idx != 7'(tgt); i++) tick();
    check("reach_idx", counter_idx, tgt);
  endtask
  task automatic wait_done();
    for (int i = 0; i < 300 && !done; i++) tick();
    check("done_seen", done, 1);
  endtask

  initial begin
    logic [1023:0] vi, e, sv;
    int n0;
    tick();
    tick();
    check("rst_v", v_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_idx", counter_idx, 0);
    rst = 0;
    g_stub = 1;
    vi = '0;
    for (int i = 0; i < 16; i++) vi = set_w(vi, i, 64'(i));
    do_start(vi, 0);
    tick();
    e = vi;
    e = set_w(e, 0, 1);
    e = set_w(e, 4, 6);
    e = set_w(e, 8, 11);
    e = set_w(e, 12, 16);
    check("map_step0", v_out, e);
    repeat (4) tick();
    check("map_s4_w0", wd(v_out, 0), 2);
    check("map_s4_w5", wd(v_out, 5), 9);
    check("map_s4_w10", wd(v_out, 10), 16);
    check("map_s4_w15", wd(v_out, 15), 23);
    check("map_s4_w1", wd(v_out, 1), 2);
    wait_done();
    tick();
    g_stub = 0;
    vi = rnd_v();
    do_start(vi, 0);
    wait_done();
    tick();
    check("done_one_cycle", done, 0);
    do_start(vi, 5);
    step_until(37);
    sv = v_out;
    en = 0;
    repeat (5) begin
      tick();
      check("stall_v", v_out, sv);
      check("stall_idx", counter_idx, 37);
      check("stall_busy", busy, 1);
    end
    en = 1;
    wait_done();
    tick();
    n0 = ndone;
    do_start(rnd_v(), 0);
    step_until(60);
    v_init = rnd_v();
    start = 1;
    tick();
    start = 0;
    check("ign_idx", counter_idx, 61);
    check("ign_busy", busy, 1);
    step_until(127);
    start = 1;
    tick();
    start = 0;
    check("term_done", done, 1);
    check("term_busy", busy, 0);
    tick();
    check("no_restart_busy", busy, 0);
    check("one_done", ndone, n0 + 1);
    do_start(rnd_v(), 0);
    wait_done();
    do_start(rnd_v(), 0);
    wait_done();
    tick();
    check("b2b_done_clear", done, 0);
    do_start(rnd_v(), 0);
    step_until(90);
    rst = 1;
    start = 1;
    v_init = rnd_v();
    void'(q.pop_back());
    tick();
    rst = 0;
    start = 0;
    check("abort_v", v_out, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_idx", counter_idx, 0);
    n0 = ndone;
    repeat (200) tick();
    check("abort_no_done", ndone, n0);
    check("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
